// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in / serial-out transmitter and its
// bit-period counter.
//   state_e : transmitter FSM states (IDLE, SHIFT)
//   max2    : larger of two integers, used to keep counter widths >= 1
// -----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_period_cnt.sv
// -----------------------------------------------------------------------------
// bit_period_cnt
// Counts clock cycles within one bit period (0..CLKS_PER_BIT-1) and pulses
// strobe on the last cycle of each period. A receiver can reuse it as its
// sample enable.
// Ports:
//   clk    : system clock, rising edge
//   r      : synchronous active-high reset
//   en     : count while high (frame in progress)
//   clr    : restart the period at 0 on the next cycle (word loaded)
//   strobe : en && counter at its terminal value
// -----------------------------------------------------------------------------
module bit_period_cnt
    import piso_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic r,
    input  logic en,
    input  logic clr,
    output logic strobe
);

    localparam int CW = max2(1, $clog2(CLKS_PER_BIT));
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            // Return to 0 at the terminal value; never count past it.
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe = en && (cnt_q == TERM);

endmodule

// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
// Loads a WIDTH-bit word through a valid/ready handshake and shifts it out
// MSB-first, each bit held CLKS_PER_BIT cycles, with a per-bit strobe on the
// last cycle of every bit period. A load on the eof cycle chains frames with
// no gap on sout_valid.
// Ports:
//   clk        : system clock, rising edge
//   r          : synchronous active-high reset (aborts a frame)
//   din        : parallel word, captured on load_valid && load_ready
//   load_valid : producer offers din
//   load_ready : transmitter can accept (idle, or final strobe of a frame)
//   sout       : serial data, MSB first
//   sout_valid : sout carries a frame bit
//   strobe     : last cycle of each bit period
//   eof        : strobe of the final bit of the frame
//   busy       : frame in progress (same as sout_valid)
// -----------------------------------------------------------------------------
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             strobe,
    output logic             eof,
    output logic             busy
);

    if (WIDTH < 2 || CLKS_PER_BIT < 1) begin : g_param_check
        $error("piso_shift_tx: WIDTH must be >= 2 and CLKS_PER_BIT >= 1");
    end

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [BW-1:0]    bcnt_q;
    logic [BW-1:0]    bcnt_d;
    logic             load_fire;
    logic             shifting;

    assign shifting   = (state_q == SHIFT);
    assign eof        = strobe && (bcnt_q == LAST_BIT);
    assign load_ready = !r && (!shifting || eof);
    assign load_fire  = load_valid && load_ready;

    bit_period_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_period (
        .clk    (clk),
        .r      (r),
        .en     (shifting),
        .clr    (load_fire),
        .strobe (strobe)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    bcnt_d  = '0;
                end
            end
            SHIFT: begin
                if (strobe) begin
                    // Zero fill leaves the register clear once a frame ends,
                    // which keeps sout low while idle.
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    if (eof) begin
                        bcnt_d = '0;
                        if (load_fire) begin
                            shreg_d = din;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign sout       = shreg_q[WIDTH-1];
    assign sout_valid = shifting;
    assign busy       = shifting;

endmodule

// File: tb/tb_piso_shift_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_tx
// Two transmitters (CLKS_PER_BIT = 1 and 3, WIDTH = 4) driven by a queue-fed
// producer. Expected outputs are computed from the frame timing rules: for a
// load accepted at cycle k, cycle t with d = t-k in 1..4*CPB carries bit
// 3-(d-1)/CPB, strobes when d is a multiple of CPB, eof when d = 4*CPB.
// A serial-in chain clocked on strobe must hold the frame word after eof.
// -----------------------------------------------------------------------------
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       r_i        [2];
    logic [3:0] din_i      [2];
    logic       lv_i       [2];
    logic       ready_w    [2];
    logic       sout_w     [2];
    logic       valid_w    [2];
    logic       strobe_w   [2];
    logic       eof_w      [2];
    logic       busy_w     [2];
    logic [3:0] chain      [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    int         cpbv      [2] = '{1, 3};
    bit         fact      [2];
    int         fk        [2];
    logic [3:0] fword     [2];
    bit         chk_chain [2];
    logic [3:0] chain_exp [2];
    bit         from_q    [2];
    bit         rst_req   [2];
    bit         pulse_en  [2];
    logic [3:0] pulse_w   [2];
    logic [3:0] q0 [$];
    logic [3:0] q1 [$];

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut0 (
        .clk(clk), .r(r_i[0]), .din(din_i[0]), .load_valid(lv_i[0]),
        .load_ready(ready_w[0]), .sout(sout_w[0]), .sout_valid(valid_w[0]),
        .strobe(strobe_w[0]), .eof(eof_w[0]), .busy(busy_w[0])
    );

    piso_shift_tx #(.WIDTH(4), .CLKS_PER_BIT(3)) dut1 (
        .clk(clk), .r(r_i[1]), .din(din_i[1]), .load_valid(lv_i[1]),
        .load_ready(ready_w[1]), .sout(sout_w[1]), .sout_valid(valid_w[1]),
        .strobe(strobe_w[1]), .eof(eof_w[1]), .busy(busy_w[1])
    );

    // downstream serial-in chains, enabled on strobe
    always @(posedge clk) if (strobe_w[0] === 1'b1) chain[0] <= {chain[0][2:0], sout_w[0]};
    always @(posedge clk) if (strobe_w[1] === 1'b1) chain[1] <= {chain[1][2:0], sout_w[1]};

    function automatic int qsize(input int n);
        return (n == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [3:0] qfront(input int n);
        return (n == 0) ? q0[0] : q1[0];
    endfunction

    task automatic push(input int n, input logic [3:0] w);
        if (n == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    task automatic pop(input int n);
        if (n == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic check(input string tag, input int n, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst%0d cyc%0d: got %0h expected %0h", tag, n, cyc, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int n = 0; n < 2; n++) begin
            r_i[n]     = rst_req[n];
            rst_req[n] = 1'b0;
            if (pulse_en[n]) begin
                lv_i[n]     = 1'b1;
                din_i[n]    = pulse_w[n];
                from_q[n]   = 1'b0;
                pulse_en[n] = 1'b0;
            end else if (qsize(n) > 0) begin
                lv_i[n]   = 1'b1;
                din_i[n]  = qfront(n);
                from_q[n] = 1'b1;
            end else begin
                lv_i[n]   = 1'b0;
                din_i[n]  = 4'($urandom);
                from_q[n] = 1'b0;
            end
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the
    // rising edge, then drive the next inputs.
    task automatic cycle();
        bit inf  [2];
        bit eeof [2];
        bit erdy [2];
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            int  d;
            int  bit_idx;
            logic esout;
            bit  estb;
            d       = cyc - fk[n];
            inf[n]  = fact[n] && (d >= 1) && (d <= 4 * cpbv[n]);
            bit_idx = inf[n] ? 3 - (d - 1) / cpbv[n] : 0;
            esout   = inf[n] ? fword[n][bit_idx] : 1'b0;
            estb    = inf[n] && (d % cpbv[n] == 0);
            eeof[n] = inf[n] && (d == 4 * cpbv[n]);
            erdy[n] = !r_i[n] && (!inf[n] || eeof[n]);
            check("sout",       n, {3'b0, sout_w[n]},   {3'b0, esout});
            check("sout_valid", n, {3'b0, valid_w[n]},  {3'b0, inf[n]});
            check("busy",       n, {3'b0, busy_w[n]},   {3'b0, inf[n]});
            check("strobe",     n, {3'b0, strobe_w[n]}, {3'b0, estb});
            check("eof",        n, {3'b0, eof_w[n]},    {3'b0, eeof[n]});
            check("load_ready", n, {3'b0, ready_w[n]},  {3'b0, erdy[n]});
            if (chk_chain[n]) begin
                check("chain", n, chain[n], chain_exp[n]);
                chk_chain[n] = 1'b0;
            end
        end
        @(posedge clk);
        for (int n = 0; n < 2; n++) begin
            if (eeof[n] && !r_i[n]) begin
                chk_chain[n] = 1'b1;
                chain_exp[n] = fword[n];
            end
            if (r_i[n]) begin
                fact[n] = 1'b0;
            end else if (lv_i[n] && erdy[n]) begin
                fact[n]  = 1'b1;
                fk[n]    = cyc;
                fword[n] = din_i[n];
                if (from_q[n]) pop(n);
            end else if (eeof[n]) begin
                fact[n] = 1'b0;
            end
        end
        cyc++;
        #1;
        drive_inputs();
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            fact[n] = 1'b0; fk[n] = 0; fword[n] = '0; chain[n] = '0;
            chk_chain[n] = 1'b0; chain_exp[n] = '0; from_q[n] = 1'b0;
            rst_req[n] = 1'b1; pulse_en[n] = 1'b0; pulse_w[n] = '0;
        end
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        // reset held for one checked cycle
        rst_req[0] = 1'b1; rst_req[1] = 1'b1;
        drive_inputs();
        cycle();
        repeat (2) cycle();

        // single frame 1011
        push(0, 4'b1011); push(1, 4'b0110);
        drive_inputs();
        repeat (16) cycle();

        // back-to-back 1001 then 0111
        push(0, 4'b1001); push(0, 4'b0111);
        push(1, 4'b1001); push(1, 4'b0111);
        drive_inputs();
        repeat (30) cycle();

        // load pulse while busy is ignored
        push(0, 4'b1100); push(1, 4'b1100);
        drive_inputs();
        cycle();
        cycle();
        pulse_en[0] = 1'b1; pulse_w[0] = 4'b1111;
        pulse_en[1] = 1'b1; pulse_w[1] = 4'b1111;
        drive_inputs();
        repeat (16) cycle();

        // reset at k+2 aborts the frame
        push(0, 4'b1011); push(1, 4'b1011);
        drive_inputs();
        cycle();
        cycle();
        rst_req[0] = 1'b1; rst_req[1] = 1'b1;
        drive_inputs();
        repeat (6) cycle();

        // randomized traffic with occasional resets
        repeat (400) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 3) == 0 && qsize(n) < 3) push(n, 4'($urandom));
                if ($urandom_range(0, 79) == 0) rst_req[n] = 1'b1;
            end
            drive_inputs();
            cycle();
        end
        repeat (40) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
